// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizes for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_NUM_REQ   = 4;
    localparam int DEFAULT_MAX_BURST = 4;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority encoder: returns the first asserted request found when
// scanning from ptr upward, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      idx,
    output logic               found
);

    logic [IW-1:0] cand;

    // Scan every position once, starting at ptr, keeping the first hit.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ
// valid/ready producers; the winner keeps the port for up to MAX_BURST beats.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int NUM_REQ   = DEFAULT_NUM_REQ,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       full,
    output logic                       wr_enb,
    output logic [WIDTH-1:0]           wr_data,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

    arb_state_t    state_q;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] rrPtr_q;
    logic [CW-1:0] beatCnt_q;

    logic [IW-1:0] nextPtr_d;
    logic [IW-1:0] pickIdx;
    logic          pickFound;
    logic          ownerValid;
    logic          portOpen;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) uPicker (
        .req   (req_valid),
        .ptr   (rrPtr_q),
        .idx   (pickIdx),
        .found (pickFound)
    );

    assign busy   = (state_q == GRANT);
    assign gnt_id = owner_q;

    // Output mux: only the owner sees ready, and nothing is written while
    // the FIFO is full or reset is asserted, regardless of registered state.
    always_comb begin
        portOpen   = busy && !full && !rst;
        ownerValid = req_valid[owner_q];
        wr_data    = '0;
        req_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IW'(i)) begin
                wr_data      = req_data[i*WIDTH +: WIDTH];
                req_ready[i] = portOpen;
            end
        end
        wr_enb    = portOpen && ownerValid;
        nextPtr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    end

    // Arbitration FSM: grant in IDLE, count beats in GRANT, and release on
    // burst completion or when the owner stops presenting data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rrPtr_q   <= '0;
            beatCnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pickFound) begin
                        owner_q   <= pickIdx;
                        beatCnt_q <= '0;
                        state_q   <= GRANT;
                    end
                end
                GRANT: begin
                    if (wr_enb) begin
                        if (beatCnt_q == LAST_BEAT) begin
                            state_q   <= IDLE;
                            rrPtr_q   <= nextPtr_d;
                            beatCnt_q <= '0;
                        end else begin
                            beatCnt_q <= beatCnt_q + 1'b1;
                        end
                    end else if (!ownerValid) begin
                        state_q   <= IDLE;
                        rrPtr_q   <= nextPtr_d;
                        beatCnt_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (WIDTH=8, NUM_REQ=4, MAX_BURST=4).
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  reqValid;
    logic [31:0] reqData;
    logic [3:0]  reqReady;
    logic        full;
    logic        wrEnb;
    logic [7:0]  wrData;
    logic [1:0]  gntId;
    logic        busy;

    int vectorCount = 0;
    int failCount   = 0;

    // Single-producer burst (producer 2): data on lane 2 per cycle and the
    // hand-derived write-enable/busy pattern, cycle 0 first.
    logic [7:0] aData [10] = '{8'hA0, 8'hA0, 8'hA1, 8'hA2, 8'hA3,
                               8'hA4, 8'hA4, 8'hA5, 8'h00, 8'h00};
    logic [0:9] aWe   = 10'b0111101100;
    logic [0:9] aBusy = 10'b0111101110;

    // Full-stall burst (producer 1), cycles 0..8.
    logic [7:0] cData [9] = '{8'hB0, 8'hB0, 8'hB1, 8'hB2, 8'hB2,
                              8'hB2, 8'hB2, 8'hB3, 8'h00};
    logic [0:8] cWe   = 9'b011000110;
    logic [0:8] cBusy = 9'b011111110;
    logic [0:8] cFull = 9'b000111000;
    logic [0:8] cVal  = 9'b111111110;

    fifo_wr_arbiter #(
        .WIDTH     (8),
        .NUM_REQ   (4),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (reqValid),
        .req_data  (reqData),
        .req_ready (reqReady),
        .full      (full),
        .wr_enb    (wrEnb),
        .wr_data   (wrData),
        .gnt_id    (gntId),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's inputs just after the falling edge, then lets the
    // combinational outputs settle before any checks.
    task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d,
                                 input logic f, input logic r);
        @(negedge clk);
        reqValid = v;
        reqData  = d;
        full     = f;
        rst      = r;
        #1;
    endtask

    // Checks every output for the current cycle; data only matters on a beat.
    task automatic checkCycle(input string tag, input logic expWe,
                              input logic expBusy, input logic [1:0] expGnt,
                              input logic [7:0] expData, input logic [3:0] expReady);
        checkOutput({tag, ".wr_enb"}, 32'(wrEnb), 32'(expWe));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(expBusy));
        checkOutput({tag, ".gnt_id"}, 32'(gntId), 32'(expGnt));
        checkOutput({tag, ".req_ready"}, 32'(reqReady), 32'(expReady));
        if (expWe)
            checkOutput({tag, ".wr_data"}, 32'(wrData), 32'(expData));
    endtask

    initial begin
        int pulses;
        int readyPulses;
        logic [1:0] expOwner;
        logic       expWe;

        reqValid = '0;
        reqData  = '0;
        full     = 1'b0;
        rst      = 1'b1;

        // Reset with every producer valid: nothing may be granted or written.
        applyStimulus(4'b1111, 32'h0, 1'b0, 1'b1);
        checkCycle("reset", 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
        applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
        checkCycle("postReset", 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);

        // Producer 2 alone, six beats: A0..A3, bubble, A4..A5, then release.
        for (int c = 0; c < 10; c++) begin
            applyStimulus((c < 8) ? 4'b0100 : 4'b0000, {8'h00, aData[c], 16'h0000},
                          1'b0, 1'b0);
            checkCycle($sformatf("single[%0d]", c), aWe[c], aBusy[c],
                       (c == 0) ? 2'd0 : 2'd2, aData[c],
                       aBusy[c] ? 4'b0100 : 4'b0000);
        end

        // Producers 0 and 3 contending: grants alternate 0,3,0,3 with 4 beats
        // each separated by a single idle cycle.
        applyStimulus(4'b0000, 32'h0, 1'b0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            applyStimulus(4'b1001, 32'h3000_0010, 1'b0, 1'b0);
            expWe    = (c % 5) != 0;
            expOwner = (c < 5) ? 2'd0 : (((c - 1) / 5) % 2 == 1) ? 2'd3 : 2'd0;
            checkCycle($sformatf("contend[%0d]", c), expWe, expWe, expOwner,
                       (expOwner == 2'd3) ? 8'h30 : 8'h10,
                       expWe ? ((expOwner == 2'd3) ? 4'b1000 : 4'b0001) : 4'b0000);
        end

        // Producer 1 burst with full high for three cycles after beat 1.
        applyStimulus(4'b0000, 32'h0, 1'b0, 1'b1);
        for (int c = 0; c < 9; c++) begin
            applyStimulus(cVal[c] ? 4'b0010 : 4'b0000, {16'h0000, cData[c], 8'h00},
                          cFull[c], 1'b0);
            checkCycle($sformatf("stall[%0d]", c), cWe[c], cBusy[c],
                       (c == 0) ? 2'd0 : 2'd1, cData[c],
                       (cBusy[c] && !cFull[c]) ? 4'b0010 : 4'b0000);
        end

        // Owner 0 drops valid after two beats; pointer moves to 1 so
        // producer 3 beats producer 0 in the next arbitration.
        applyStimulus(4'b0000, 32'h0, 1'b0, 1'b1);
        applyStimulus(4'b0001, 32'h0000_00C0, 1'b0, 1'b0);
        checkCycle("drop[0]", 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
        applyStimulus(4'b0001, 32'h0000_00C0, 1'b0, 1'b0);
        checkCycle("drop[1]", 1'b1, 1'b1, 2'd0, 8'hC0, 4'b0001);
        applyStimulus(4'b0001, 32'h0000_00C1, 1'b0, 1'b0);
        checkCycle("drop[2]", 1'b1, 1'b1, 2'd0, 8'hC1, 4'b0001);
        applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
        checkCycle("drop[3]", 1'b0, 1'b1, 2'd0, 8'h00, 4'b0001);
        applyStimulus(4'b1001, 32'hD000_00C2, 1'b0, 1'b0);
        checkCycle("drop[4]", 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
        applyStimulus(4'b1001, 32'hD000_00C2, 1'b0, 1'b0);
        checkCycle("drop[5]", 1'b1, 1'b1, 2'd3, 8'hD0, 4'b1000);
        applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
        checkCycle("drop[6]", 1'b0, 1'b1, 2'd3, 8'h00, 4'b1000);
        applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
        checkCycle("drop[7]", 1'b0, 1'b0, 2'd3, 8'h00, 4'b0000);

        // Move the pointer to 3, start a producer 1 burst, reset during beat 2;
        // afterwards the pointer is 0 so producer 2 beats producer 3.
        applyStimulus(4'b0100, 32'h00E0_0000, 1'b0, 1'b0);
        checkCycle("rstMid[0]", 1'b0, 1'b0, 2'd3, 8'h00, 4'b0000);
        applyStimulus(4'b0100, 32'h00E0_0000, 1'b0, 1'b0);
        checkCycle("rstMid[1]", 1'b1, 1'b1, 2'd2, 8'hE0, 4'b0100);
        applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
        checkCycle("rstMid[2]", 1'b0, 1'b1, 2'd2, 8'h00, 4'b0100);
        applyStimulus(4'b0010, 32'h0000_E100, 1'b0, 1'b0);
        checkCycle("rstMid[3]", 1'b0, 1'b0, 2'd2, 8'h00, 4'b0000);
        applyStimulus(4'b0010, 32'h0000_E100, 1'b0, 1'b0);
        checkCycle("rstMid[4]", 1'b1, 1'b1, 2'd1, 8'hE1, 4'b0010);
        applyStimulus(4'b0010, 32'h0000_E200, 1'b0, 1'b0);
        checkCycle("rstMid[5]", 1'b1, 1'b1, 2'd1, 8'hE2, 4'b0010);
        applyStimulus(4'b0010, 32'h0000_E300, 1'b0, 1'b1);
        checkCycle("rstMid[6]", 1'b0, 1'b1, 2'd1, 8'h00, 4'b0000);
        applyStimulus(4'b1100, 32'hF3F2_0000, 1'b0, 1'b0);
        checkCycle("rstMid[7]", 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
        applyStimulus(4'b1100, 32'hF3F2_0000, 1'b0, 1'b0);
        checkCycle("rstMid[8]", 1'b1, 1'b1, 2'd2, 8'hF2, 4'b0100);
        applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
        checkCycle("rstMid[9]", 1'b0, 1'b1, 2'd2, 8'h00, 4'b0100);
        applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
        checkCycle("rstMid[10]", 1'b0, 1'b0, 2'd2, 8'h00, 4'b0000);

        // Full held high with everyone valid: no writes and no ready at all;
        // pointer is 3, so producer 3 takes and holds the grant.
        pulses      = 0;
        readyPulses = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(4'b1111, 32'h3322_1100, 1'b1, 1'b0);
            if (wrEnb !== 1'b0) pulses++;
            if (reqReady !== 4'b0000) readyPulses++;
        end
        checkOutput("fullHold.wr_enb_pulses", 32'(pulses), 32'd0);
        checkOutput("fullHold.ready_pulses", 32'(readyPulses), 32'd0);
        checkOutput("fullHold.busy", 32'(busy), 32'd1);
        checkOutput("fullHold.gnt_id", 32'(gntId), 32'd3);

        // Full falling allows a beat in that same cycle.
        applyStimulus(4'b1111, 32'h3322_1100, 1'b0, 1'b0);
        checkCycle("fullFall", 1'b1, 1'b1, 2'd3, 8'h33, 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule
